// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// First protocol stage behind the UART receiver. Hunts for HEADER, reads a
// length byte, buffers LEN payload bytes, verifies an 8-bit additive checksum
// (LEN plus payload, HEADER excluded) and only then streams the payload out.
// Frames with a bad length, a bad checksum or an inter-byte stall longer than
// TIMEOUT_CYCLES are discarded and reported with a one-cycle frame_err pulse.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   rx_data        byte from UART receiver
//   rx_data_valid  rx_data valid
//   rx_data_ready  parser can accept a byte (low while streaming a frame out)
//   out_data       verified payload byte
//   out_valid      out_data valid
//   out_last       final payload byte of the frame
//   out_ready      downstream accepts out_data
//   frame_err      one-cycle pulse when a frame is discarded
//   err_code       cause of last discard: 1 bad length, 2 checksum, 3 timeout
// -----------------------------------------------------------------------------
module uart_frame_parser #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  HEADER         = 8'h55,
   parameter int unsigned TIMEOUT_CYCLES = 8680
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid,
   output logic       rx_data_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
   // The limit is reached when the counter would step onto TIMEOUT_CYCLES.
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHECK,
      S_SEND
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_SUM     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   state_t           state, state_next;
   err_t             err_cause;
   logic             err_fire;
   logic [7:0]       len, len_m1, sum;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [15:0]      tmo_cnt;
   logic             accept, in_frame, tmo_hit;
   logic [7:0]       frame_buf [MAX_LEN];

   assign len_m1        = len - 8'd1;
   assign rx_data_ready = !rst && (state != S_SEND);
   assign accept        = rx_data_valid && rx_data_ready;
   assign in_frame      = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
   // An accepted byte always beats the timeout in the same cycle.
   assign tmo_hit       = TMO_EN && in_frame && !accept && (tmo_cnt == TMO_LAST);

   assign out_valid = (state == S_SEND);
   assign out_data  = out_valid ? frame_buf[rd_idx] : 8'h00;
   assign out_last  = out_valid && (rd_idx == len_m1[IDX_W-1:0]);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_next = state;
      err_fire   = 1'b0;
      err_cause  = ERR_NONE;
      unique case (state)
         S_IDLE: begin
            // Header hunting: anything else is silently dropped.
            if (accept && rx_data == HEADER) state_next = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  err_fire   = 1'b1;
                  err_cause  = ERR_LEN;
                  state_next = S_IDLE;
               end else begin
                  state_next = S_PAYLOAD;
               end
            end else if (tmo_hit) begin
               err_fire   = 1'b1;
               err_cause  = ERR_TIMEOUT;
               state_next = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               if (wr_idx == len_m1[IDX_W-1:0]) state_next = S_CHECK;
            end else if (tmo_hit) begin
               err_fire   = 1'b1;
               err_cause  = ERR_TIMEOUT;
               state_next = S_IDLE;
            end
         end
         S_CHECK: begin
            // A byte equal to HEADER here is just a checksum candidate.
            if (accept) begin
               if (rx_data == sum) begin
                  state_next = S_SEND;
               end else begin
                  err_fire   = 1'b1;
                  err_cause  = ERR_SUM;
                  state_next = S_IDLE;
               end
            end else if (tmo_hit) begin
               err_fire   = 1'b1;
               err_cause  = ERR_TIMEOUT;
               state_next = S_IDLE;
            end
         end
         S_SEND: begin
            if (out_ready && out_last) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register and frame bookkeeping
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state     <= S_IDLE;
         len       <= 8'd0;
         sum       <= 8'd0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         tmo_cnt   <= 16'd0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         state     <= state_next;
         frame_err <= err_fire;
         if (err_fire) err_code <= err_cause;

         // Counter restarts on every accepted byte; entry into the in-frame
         // states always coincides with an accepted byte.
         if (in_frame && !accept) tmo_cnt <= tmo_cnt + 16'd1;
         else                     tmo_cnt <= 16'd0;

         unique case (state)
            S_LEN: begin
               if (accept) begin
                  len    <= rx_data;
                  sum    <= rx_data;
                  wr_idx <= '0;
               end
            end
            S_PAYLOAD: begin
               if (accept) begin
                  sum    <= sum + rx_data;
                  wr_idx <= wr_idx + 1'b1;
               end
            end
            S_CHECK: begin
               if (accept) rd_idx <= '0;
            end
            S_SEND: begin
               if (out_ready) rd_idx <= rd_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the payload buffer has no reset; it is always fully rewritten before
   // S_SEND reads it, and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && accept) frame_buf[wr_idx] <= rx_data;
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Directed and randomized stimulus for uart_frame_parser. Expected payload
// bytes and error codes come from a frame-level reference model that walks the
// sent byte list (with the idle gap before each byte) and applies the framing,
// length, checksum and timeout rules directly.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

   localparam int         MAX_LEN = 16;
   localparam int         TMO     = 8680;
   localparam logic [7:0] HDR     = 8'h55;

   logic       clk           = 1'b0;
   logic       rst           = 1'b1;
   logic [7:0] rx_data       = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic       rx_data_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready     = 1'b1;
   logic       frame_err;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   uart_frame_parser #(
      .MAX_LEN       (MAX_LEN),
      .HEADER        (HDR),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_data_valid(rx_data_valid),
      .rx_data_ready(rx_data_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .frame_err    (frame_err),
      .err_code     (err_code)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Stimulus: byte list plus idle cycles inserted before each byte.
   logic [7:0] stim_b[$];
   int         stim_g[$];

   // Reference results and observed results.
   logic [7:0] exp_data[$];
   bit         exp_last[$];
   logic [1:0] exp_err[$];
   logic [1:0] exp_code = 2'd0;

   logic [7:0] obs_data[$];
   bit         obs_last[$];
   int         obs_cyc[$];
   logic [1:0] obs_err[$];

   task automatic add(input logic [7:0] b, input int g);
      stim_b.push_back(b);
      stim_g.push_back(g);
   endtask

   task automatic clear_all();
      stim_b.delete();  stim_g.delete();
      exp_data.delete(); exp_last.delete(); exp_err.delete();
      obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_err.delete();
   endtask

   // Frame-level model. 'tail' is the idle time after the final byte.
   function automatic void run_model(input int tail);
      int         i, n, len;
      logic [7:0] s;
      logic [7:0] pl[$];
      i = 0;
      n = stim_b.size();
      while (i < n) begin
         if (stim_b[i] != HDR) begin
            i++;
            continue;
         end
         i++;
         if (i >= n) begin
            if (tail >= TMO) exp_err.push_back(2'd3);
            break;
         end
         if (stim_g[i] >= TMO) begin
            exp_err.push_back(2'd3);
            continue;
         end
         len = int'(stim_b[i]);
         i++;
         if (len == 0 || len > MAX_LEN) begin
            exp_err.push_back(2'd1);
            continue;
         end
         s = 8'(len);
         pl.delete();
         for (int k = 0; k <= len; k++) begin
            if (i >= n) begin
               if (tail >= TMO) exp_err.push_back(2'd3);
               break;
            end
            if (stim_g[i] >= TMO) begin
               exp_err.push_back(2'd3);
               break;
            end
            if (k < len) begin
               pl.push_back(stim_b[i]);
               s = s + stim_b[i];
            end else if (stim_b[i] == s) begin
               for (int j = 0; j < pl.size(); j++) begin
                  exp_data.push_back(pl[j]);
                  exp_last.push_back(j == pl.size() - 1);
               end
            end else begin
               exp_err.push_back(2'd2);
            end
            i++;
         end
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor: drives out_ready for the coming edge, then samples at negedge.
   // rdy_mode: 0 always ready, 1 fixed pattern, 2 random, 3 never ready.
   // ---------------------------------------------------------------------------
   int         ncyc     = 0;
   int         acc_cyc  = 0;
   int         rdy_mode = 0;
   int         pidx     = 0;
   bit [5:0]   pat      = 6'b101001;   // 1,0,0,1,0,1 from bit 0 upward
   bit         stall_prev = 1'b0;
   bit         err_prev   = 1'b0;
   logic [7:0] prev_d     = 8'h00;
   bit         prev_l     = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         ncyc++;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = pat[pidx % 6];
               if (out_valid) pidx++;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_d);
            check("hold_last", out_last, prev_l);
         end
         if (out_valid) check("rx_ready_in_send", rx_data_ready, 0);
         if (out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            obs_cyc.push_back(ncyc);
         end
         if (rst) stall_prev = 1'b0;
         else     stall_prev = out_valid && !out_ready;
         prev_d = out_data;
         prev_l = out_last;
         if (frame_err) begin
            check("err_pulse_width", err_prev, 0);
            obs_err.push_back(err_code);
         end
         err_prev = frame_err;
         if (rx_data_valid && rx_data_ready) acc_cyc = ncyc;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(posedge clk); #1;
         rx_data_valid = 1'b0;
      end
      @(posedge clk); #1;
      rx_data_valid = 1'b1;
      rx_data       = b;
      n = 0;
      while (!rx_data_ready && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rx_data_ready) check("rx_ready_wait", rx_data_ready, 1);
   endtask

   task automatic drive_stim();
      for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_g[i]);
      @(posedge clk); #1;
      rx_data_valid = 1'b0;
   endtask

   task automatic run_segment(input string name, input int tail);
      int n;
      obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_err.delete();
      exp_data.delete(); exp_last.delete(); exp_err.delete();
      run_model(tail);
      drive_stim();
      repeat (tail) @(posedge clk);
      n = 0;
      while (out_valid && n < 4000) begin
         @(posedge clk);
         n++;
      end
      if (out_valid) check({name, ":drain"}, out_valid, 0);
      @(negedge clk);
      @(negedge clk);
      check({name, ":out_count"}, obs_data.size(), exp_data.size());
      for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
         check({name, ":out_data"}, obs_data[k], exp_data[k]);
         check({name, ":out_last"}, obs_last[k], exp_last[k]);
      end
      check({name, ":err_count"}, obs_err.size(), exp_err.size());
      for (int k = 0; k < exp_err.size() && k < obs_err.size(); k++)
         check({name, ":err_code_evt"}, obs_err[k], exp_err[k]);
      if (exp_err.size() > 0) exp_code = exp_err[exp_err.size() - 1];
      check({name, ":err_code_hold"}, err_code, exp_code);
      stim_b.delete();
      stim_g.delete();
   endtask

   task automatic gen_random(input int nframes);
      int         kind, len;
      logic [7:0] s, b;
      for (int f = 0; f < nframes; f++) begin
         kind = int'($urandom_range(0, 9));
         if (kind <= 7) begin
            len = int'($urandom_range(1, MAX_LEN));
            add(HDR, int'($urandom_range(0, 3)));
            add(8'(len), int'($urandom_range(0, 3)));
            s = 8'(len);
            for (int k = 0; k < len; k++) begin
               b = 8'($urandom);
               s = s + b;
               add(b, int'($urandom_range(0, 3)));
            end
            if (kind >= 6) s = s + 8'($urandom_range(1, 255));
            add(s, int'($urandom_range(0, 3)));
         end else if (kind == 8) begin
            add(HDR, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) add(8'h00, 0);
            else                           add(8'($urandom_range(MAX_LEN + 1, 255)), 0);
         end else begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               b = 8'($urandom);
               if (b == HDR) b = 8'h56;
               add(b, int'($urandom_range(0, 3)));
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      clear_all();

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst:rx_data_ready", rx_data_ready, 0);
      check("rst:out_valid", out_valid, 0);
      check("rst:out_last", out_last, 0);
      check("rst:out_data", out_data, 8'h00);
      check("rst:frame_err", frame_err, 0);
      check("rst:err_code", err_code, 2'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst:rx_data_ready", rx_data_ready, 1);

      // Good frame, out_ready held high: latency and back-to-back output
      rdy_mode = 0;
      add(HDR, 0); add(8'h03, 0); add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h69, 0);
      run_segment("good", 5);
      for (int k = 0; k < obs_cyc.size(); k++) check("good:out_cycle", obs_cyc[k], acc_cyc + 1 + k);

      // Same frame under back-pressure pattern 1,0,0,1,0,1
      rdy_mode = 1;
      pidx     = 0;
      add(HDR, 2); add(8'h03, 0); add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h69, 0);
      run_segment("backpressure", 5);
      rdy_mode = 0;

      // Bad checksum followed by a one-byte frame
      add(HDR, 1); add(8'h02, 0); add(8'hAA, 0); add(8'hBB, 0); add(8'h00, 0);
      add(HDR, 0); add(8'h01, 0); add(8'h7E, 0); add(8'h7F, 0);
      run_segment("bad_sum", 5);

      // Junk, zero length, over-long length
      add(8'h00, 1); add(8'hFF, 0); add(8'h12, 2);
      add(HDR, 0); add(8'h00, 0);
      add(HDR, 3); add(8'h11, 0);
      run_segment("bad_len", 5);

      // Timeout exactly at the limit, then a good frame proves return to idle
      add(HDR, 0); add(8'h04, 0); add(8'h01, 0);
      add(HDR, TMO); add(8'h01, 0); add(8'h7E, 0); add(8'h7F, 0);
      run_segment("timeout", 5);

      // One cycle short of the limit completes normally
      add(HDR, 0); add(8'h04, 0); add(8'h01, 0);
      add(8'h02, TMO - 1); add(8'h03, 0); add(8'h04, 0); add(8'h0E, 0);
      run_segment("timeout_minus1", 5);

      // Reset while stalled in the send phase: nothing further is emitted
      obs_data.delete(); obs_err.delete();
      rdy_mode = 3;
      add(HDR, 0); add(8'h02, 0); add(8'h01, 0); add(8'h02, 0); add(8'h05, 0);
      drive_stim();
      stim_b.delete(); stim_g.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_send:out_valid", out_valid, 1);
      check("mid_send:out_data", out_data, 8'h01);
      check("mid_send:out_last", out_last, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_send_rst:out_valid", out_valid, 0);
      check("mid_send_rst:out_data", out_data, 8'h00);
      check("mid_send_rst:rx_data_ready", rx_data_ready, 0);
      @(posedge clk); #1;
      rst      = 1'b0;
      rdy_mode = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("mid_send_rst:no_output", obs_data.size(), 0);
      check("mid_send_rst:no_err", obs_err.size(), 0);

      // Reset mid-frame, then a fresh frame
      obs_data.delete(); obs_err.delete();
      add(HDR, 0); add(8'h03, 0); add(8'h11, 0);
      drive_stim();
      stim_b.delete(); stim_g.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_frame_rst:rx_data_ready", rx_data_ready, 0);
      check("mid_frame_rst:out_valid", out_valid, 0);
      check("mid_frame_rst:frame_err", frame_err, 0);
      check("mid_frame_rst:err_code", err_code, 2'd0);
      exp_code = 2'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("mid_frame_rst:no_output", obs_data.size(), 0);
      check("mid_frame_rst:no_err", obs_err.size(), 0);
      add(HDR, 0); add(8'h01, 0); add(8'h09, 0); add(8'h0A, 0);
      run_segment("after_rst", 5);

      // Randomized frames with random downstream back-pressure
      rdy_mode = 2;
      gen_random(40);
      run_segment("random", 40);
      rdy_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
